// File: rtl/ctrl_packet_rx.sv
// Purpose : host-to-FPGA command deframer; pops {cmd[2:0],len[4:0]} + len payload bytes from the
//           input FIFO and presents header, then payload, on valid/ready handshakes.
// Latency : header valid 2 cycles after its FIFO read is accepted; each payload byte likewise;
//           the FIFO is read at most once every 2 cycles.
// Backpressure: no FIFO read is issued while a header or payload byte waits for its ready, so
//           a stalled consumer loses nothing; a FIFO that stays empty mid-payload aborts the packet.
//
// Ports:
//   clk_i / reset_n_i                 single clock, synchronous active-low reset
//   rd_in_fifo_clk_o                  FIFO read clock (= clk_i)
//   rd_in_fifo_en_o                   FIFO read strobe; read accepted when en=1 and empty=0
//   rd_in_fifo_data_i                 FIFO data, valid the cycle after an accepted read
//   rd_in_fifo_empty_i                FIFO empty flag
//   hdr_valid_o/hdr_ready_i           header handshake, fields on hdr_cmd_o / hdr_len_o
//   pl_valid_o/pl_ready_i             payload handshake, byte on pl_data_o, pl_last_o on final byte
//   abort_o                           1-cycle pulse when a packet is truncated by timeout
//   led_ctrl_err_o                    sticky error (oversize header or timeout)
module ctrl_packet_rx #(
  parameter int MAX_LEN     = 31,
  parameter int TIMEOUT_CYC = 24576
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  output logic       rd_in_fifo_clk_o,
  output logic       rd_in_fifo_en_o,
  input  logic [7:0] rd_in_fifo_data_i,
  input  logic       rd_in_fifo_empty_i,
  output logic       hdr_valid_o,
  input  logic       hdr_ready_i,
  output logic [2:0] hdr_cmd_o,
  output logic [4:0] hdr_len_o,
  output logic       pl_valid_o,
  input  logic       pl_ready_i,
  output logic [7:0] pl_data_o,
  output logic       pl_last_o,
  output logic       abort_o,
  output logic       led_ctrl_err_o
);

  localparam int            TW        = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  // Six bits so the oversize compare stays meaningful even when MAX_LEN is 31.
  localparam logic [5:0]    MAX_LEN_W = 6'(MAX_LEN);

  typedef enum logic [2:0] {
    S_HDR_RD  = 3'd0,
    S_HDR_CAP = 3'd1,
    S_HDR_OUT = 3'd2,
    S_PL_RD   = 3'd3,
    S_PL_CAP  = 3'd4,
    S_PL_OUT  = 3'd5,
    S_DROP    = 3'd6
  } state_t;

  state_t        r_state;
  logic          r_arm;        // a read may be issued this cycle (cleared while data is in flight)
  logic [4:0]    r_cnt;        // payload bytes still owed for the current packet
  logic [TW-1:0] r_tcnt;       // consecutive empty cycles while waiting for a payload byte
  logic [2:0]    r_cmd;
  logic [4:0]    r_len;
  logic          r_hdr_vld;
  logic [7:0]    r_pl_dat;
  logic          r_pl_vld;
  logic          r_pl_last;
  logic          r_abort;
  logic          r_err;

  state_t        w_state_nxt;
  logic          w_arm_nxt;
  logic [4:0]    w_cnt_nxt;
  logic [TW-1:0] w_tcnt_nxt;
  logic [2:0]    w_cmd_nxt;
  logic [4:0]    w_len_nxt;
  logic          w_hdr_vld_nxt;
  logic [7:0]    w_pl_dat_nxt;
  logic          w_pl_vld_nxt;
  logic          w_pl_last_nxt;
  logic          w_abort_nxt;
  logic          w_err_nxt;

  logic          w_rd_en;
  logic          w_oversize;

  // Reads are suppressed while reset is asserted so a byte popped in the reset
  // cycle cannot be silently lost; after reset the first byte is a header.
  assign w_rd_en    = r_arm & ~rd_in_fifo_empty_i & reset_n_i;
  assign w_oversize = ({1'b0, rd_in_fifo_data_i[4:0]} > MAX_LEN_W);

  always_comb begin
    w_state_nxt   = r_state;
    w_arm_nxt     = r_arm;
    w_cnt_nxt     = r_cnt;
    w_tcnt_nxt    = r_tcnt;
    w_cmd_nxt     = r_cmd;
    w_len_nxt     = r_len;
    w_hdr_vld_nxt = r_hdr_vld;
    w_pl_dat_nxt  = r_pl_dat;
    w_pl_vld_nxt  = r_pl_vld;
    w_pl_last_nxt = r_pl_last;
    w_abort_nxt   = 1'b0;
    w_err_nxt     = r_err;

    case (r_state)
      S_HDR_RD: begin
        if (w_rd_en) begin
          w_arm_nxt   = 1'b0;
          w_state_nxt = S_HDR_CAP;
        end else begin
          w_arm_nxt   = 1'b1;
        end
      end

      S_HDR_CAP: begin
        w_cmd_nxt = rd_in_fifo_data_i[7:5];
        w_len_nxt = rd_in_fifo_data_i[4:0];
        if (w_oversize) begin
          // Length is above MAX_LEN, hence at least 1: cnt never starts at 0 in DROP.
          w_err_nxt   = 1'b1;
          w_cnt_nxt   = rd_in_fifo_data_i[4:0];
          w_arm_nxt   = 1'b1;
          w_state_nxt = S_DROP;
        end else begin
          w_hdr_vld_nxt = 1'b1;
          w_state_nxt   = S_HDR_OUT;
        end
      end

      S_HDR_OUT: begin
        if (hdr_ready_i) begin
          w_hdr_vld_nxt = 1'b0;
          w_arm_nxt     = 1'b1;
          if (r_len == 5'd0) begin
            w_state_nxt = S_HDR_RD;
          end else begin
            w_cnt_nxt   = r_len;
            w_tcnt_nxt  = '0;
            w_state_nxt = S_PL_RD;
          end
        end
      end

      S_PL_RD: begin
        if (w_rd_en) begin
          w_arm_nxt   = 1'b0;
          w_tcnt_nxt  = '0;
          w_state_nxt = S_PL_CAP;
        end else if (rd_in_fifo_empty_i) begin
          // An accepted read needs a non-empty FIFO, so a read always beats the timeout.
          if (r_tcnt == TO_LAST) begin
            w_abort_nxt = 1'b1;
            w_err_nxt   = 1'b1;
            w_tcnt_nxt  = '0;
            w_arm_nxt   = 1'b1;
            w_state_nxt = S_HDR_RD;
          end else begin
            w_tcnt_nxt  = r_tcnt + TW'(1);
          end
        end
      end

      S_PL_CAP: begin
        w_pl_dat_nxt  = rd_in_fifo_data_i;
        w_pl_vld_nxt  = 1'b1;
        w_pl_last_nxt = (r_cnt == 5'd1);
        w_state_nxt   = S_PL_OUT;
      end

      S_PL_OUT: begin
        if (pl_ready_i) begin
          w_pl_vld_nxt  = 1'b0;
          w_pl_last_nxt = 1'b0;
          w_arm_nxt     = 1'b1;
          // r_cnt is at least 1 here, so the decrement cannot wrap.
          w_cnt_nxt     = r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            w_state_nxt = S_HDR_RD;
          end else begin
            w_tcnt_nxt  = '0;
            w_state_nxt = S_PL_RD;
          end
        end
      end

      S_DROP: begin
        // Alternates read / capture exactly like the payload path, but the byte is
        // thrown away and an empty FIFO is waited out indefinitely.
        if (w_rd_en) begin
          w_arm_nxt = 1'b0;
          w_cnt_nxt = r_cnt - 5'd1;
        end else if (!r_arm) begin
          w_arm_nxt = 1'b1;
          if (r_cnt == 5'd0) begin
            w_state_nxt = S_HDR_RD;
          end
        end
      end

      default: begin
        w_arm_nxt   = 1'b0;
        w_state_nxt = S_HDR_RD;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state   <= S_HDR_RD;
      r_arm     <= 1'b0;
      r_cnt     <= '0;
      r_tcnt    <= '0;
      r_cmd     <= '0;
      r_len     <= '0;
      r_hdr_vld <= 1'b0;
      r_pl_dat  <= '0;
      r_pl_vld  <= 1'b0;
      r_pl_last <= 1'b0;
      r_abort   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_arm     <= w_arm_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_cmd     <= w_cmd_nxt;
      r_len     <= w_len_nxt;
      r_hdr_vld <= w_hdr_vld_nxt;
      r_pl_dat  <= w_pl_dat_nxt;
      r_pl_vld  <= w_pl_vld_nxt;
      r_pl_last <= w_pl_last_nxt;
      r_abort   <= w_abort_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign rd_in_fifo_clk_o = clk_i;
  assign rd_in_fifo_en_o  = w_rd_en;
  assign hdr_valid_o      = r_hdr_vld;
  assign hdr_cmd_o        = r_cmd;
  assign hdr_len_o        = r_len;
  assign pl_valid_o       = r_pl_vld;
  assign pl_data_o        = r_pl_dat;
  assign pl_last_o        = r_pl_last;
  assign abort_o          = r_abort;
  assign led_ctrl_err_o   = r_err;

endmodule

// File: tb/tb_ctrl_packet_rx.sv
// Purpose : self-checking bench for ctrl_packet_rx with a FIFO model and a packet-level scoreboard.
// Latency : n/a (bench).
// Backpressure: consumer readiness is driven tied-high, targeted-low or random per scenario.
module tb_ctrl_packet_rx;

  localparam int MAX_LEN     = 4;
  localparam int TIMEOUT_CYC = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       fifo_clk;
  logic       rd_en;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       hdr_valid;
  logic       hdr_ready;
  logic [2:0] hdr_cmd;
  logic [4:0] hdr_len;
  logic       pl_valid;
  logic       pl_ready;
  logic [7:0] pl_data;
  logic       pl_last;
  logic       abort;
  logic       led_err;

  always #5 clk = ~clk;

  ctrl_packet_rx #(
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_i              (clk),
    .reset_n_i          (reset_n),
    .rd_in_fifo_clk_o   (fifo_clk),
    .rd_in_fifo_en_o    (rd_en),
    .rd_in_fifo_data_i  (fifo_data),
    .rd_in_fifo_empty_i (fifo_empty),
    .hdr_valid_o        (hdr_valid),
    .hdr_ready_i        (hdr_ready),
    .hdr_cmd_o          (hdr_cmd),
    .hdr_len_o          (hdr_len),
    .pl_valid_o         (pl_valid),
    .pl_ready_i         (pl_ready),
    .pl_data_o          (pl_data),
    .pl_last_o          (pl_last),
    .abort_o            (abort),
    .led_ctrl_err_o     (led_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // FIFO contents and expected consumer-side transactions.
  logic [7:0] fifo_q[$];
  logic [7:0] exp_hdr[$];   // {cmd, len}
  logic [8:0] exp_pl[$];    // {last, byte}
  bit         err_exp;

  int         cyc = 0;
  int         abort_cnt;
  int         abort_cyc;
  int         last_pl_cyc;
  bit         rst_req;
  bit         pop_pend;
  logic [7:0] pop_byte;
  bit         acc_prev;
  bit         hdr_hold;
  bit         pl_hold;
  logic [7:0] hdr_prev;
  logic [8:0] pl_prev;
  int         rdy_mode;
  int         stall_pct;
  int         bp_cnt;
  int         pl_in_pkt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Packet-level model: a header with len above MAX_LEN is swallowed together with its
  // len bytes and raises the error flag; otherwise the header and every supplied byte
  // reach the consumer, with last only on the final byte of a complete packet.
  task automatic send_pkt(input logic [2:0] cmd, input logic [4:0] len,
                          input logic [7:0] pl[$], input bit complete);
    fifo_q.push_back({cmd, len});
    foreach (pl[i]) fifo_q.push_back(pl[i]);
    if (int'(len) > MAX_LEN) begin
      err_exp = 1'b1;
    end else begin
      exp_hdr.push_back({cmd, len});
      foreach (pl[i]) exp_pl.push_back({complete && (i == pl.size() - 1), pl[i]});
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, observe 1 ns later.
  task automatic step();
    bit acc;
    @(negedge clk);
    reset_n = !rst_req;
    if (pop_pend) begin
      fifo_data = pop_byte;
      pop_pend  = 1'b0;
    end
    fifo_empty = (fifo_q.size() == 0) || ($urandom_range(0, 99) < stall_pct);
    case (rdy_mode)
      0: begin
        hdr_ready = 1'b1;
        pl_ready  = 1'b1;
      end
      1: begin
        hdr_ready = ($urandom_range(0, 2) != 0);
        pl_ready  = ($urandom_range(0, 2) != 0);
      end
      default: begin
        hdr_ready = 1'b1;
        pl_ready  = 1'b1;
        if (pl_valid === 1'b1 && pl_in_pkt == 1 && bp_cnt < 10) begin
          pl_ready = 1'b0;
          bp_cnt++;
        end
      end
    endcase
    #1;
    if (reset_n) begin
      check_eq("vld_exclusive", hdr_valid & pl_valid, 0);
      if (hdr_hold) begin
        check_eq("hdr_vld_hold", hdr_valid, 1);
        check_eq("hdr_stable", {hdr_cmd, hdr_len}, hdr_prev);
      end
      if (pl_hold) begin
        check_eq("pl_vld_hold", pl_valid, 1);
        check_eq("pl_stable", {pl_last, pl_data}, pl_prev);
      end
      if (acc_prev) check_eq("one_outstanding", rd_en, 0);
      if (hdr_valid === 1'b1 || pl_valid === 1'b1) check_eq("no_read_while_vld", rd_en, 0);

      if (hdr_valid === 1'b1 && hdr_ready) begin
        pl_in_pkt = 0;
        if (exp_hdr.size() == 0) check_eq("hdr_extra", hdr_valid & hdr_ready, 0);
        else                     check_eq("hdr_fields", {hdr_cmd, hdr_len}, exp_hdr.pop_front());
      end
      if (pl_valid === 1'b1 && pl_ready) begin
        pl_in_pkt++;
        last_pl_cyc = cyc;
        if (exp_pl.size() == 0) check_eq("pl_extra", pl_valid & pl_ready, 0);
        else                    check_eq("pl_byte", {pl_last, pl_data}, exp_pl.pop_front());
      end
      if (abort === 1'b1) begin
        abort_cnt++;
        abort_cyc = cyc;
      end

      hdr_hold = (hdr_valid === 1'b1) && !hdr_ready;
      hdr_prev = {hdr_cmd, hdr_len};
      pl_hold  = (pl_valid === 1'b1) && !pl_ready;
      pl_prev  = {pl_last, pl_data};
      acc      = (rd_en === 1'b1) && !fifo_empty;
      if (acc) begin
        pop_byte = fifo_q.pop_front();
        pop_pend = 1'b1;
      end
      acc_prev = acc;
    end else begin
      hdr_hold = 1'b0;
      pl_hold  = 1'b0;
      acc_prev = 1'b0;
    end
    cyc++;
  endtask

  task automatic run_drain(input int budget);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || exp_hdr.size() != 0 || exp_pl.size() != 0 || pop_pend)
           && n < budget) begin
      step();
      n++;
    end
    check_eq("drain_in_budget", n < budget, 1);
    repeat (4) step();
  endtask

  task automatic do_reset(input string tag);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    fifo_q.delete();
    exp_hdr.delete();
    exp_pl.delete();
    err_exp   = 1'b0;
    pl_in_pkt = 0;
    step();
    check_eq({tag, "_rd_en"},   rd_en,     0);
    check_eq({tag, "_hdr_vld"}, hdr_valid, 0);
    check_eq({tag, "_hdr_cmd"}, hdr_cmd,   0);
    check_eq({tag, "_hdr_len"}, hdr_len,   0);
    check_eq({tag, "_pl_vld"},  pl_valid,  0);
    check_eq({tag, "_pl_dat"},  pl_data,   0);
    check_eq({tag, "_pl_last"}, pl_last,   0);
    check_eq({tag, "_abort"},   abort,     0);
    check_eq({tag, "_err"},     led_err,   0);
    check_eq({tag, "_fifo_clk"}, fifo_clk, clk);
  endtask

  initial begin
    logic [7:0] pq[$];
    int         n;
    int         len;
    logic [2:0] cmd;

    reset_n    = 1'b0;
    rst_req    = 1'b1;
    fifo_empty = 1'b1;
    fifo_data  = 8'h00;
    hdr_ready  = 1'b0;
    pl_ready   = 1'b0;
    rdy_mode   = 0;
    stall_pct  = 0;
    bp_cnt     = 0;
    abort_cnt  = 0;
    abort_cyc  = 0;
    last_pl_cyc = 0;
    pop_pend   = 1'b0;
    err_exp    = 1'b0;
    step();
    do_reset("reset");

    // Header-only command, then a normal 3-byte packet with ready tied high.
    pq.delete();
    send_pkt(3'd7, 5'd0, pq, 1'b1);
    run_drain(200);
    pq.delete(); pq.push_back(8'hAA); pq.push_back(8'h55); pq.push_back(8'h0F);
    send_pkt(3'd1, 5'd3, pq, 1'b1);
    run_drain(200);

    // Same packet, consumer stalls 10 cycles on the second byte.
    rdy_mode = 2;
    bp_cnt   = 0;
    send_pkt(3'd1, 5'd3, pq, 1'b1);
    run_drain(300);
    check_eq("bp_stall_cycles", bp_cnt, 10);
    rdy_mode = 0;
    check_eq("err_clean", led_err, 0);
    check_eq("abort_none", abort_cnt, 0);

    // Oversize header (len 6 > MAX_LEN) is dropped, next packet still delivered.
    pq.delete();
    for (int i = 0; i < 6; i++) pq.push_back(8'(8'hB0 + i));
    send_pkt(3'd0, 5'd6, pq, 1'b1);
    pq.delete(); pq.push_back(8'h77);
    send_pkt(3'd2, 5'd1, pq, 1'b1);
    run_drain(300);
    check_eq("err_oversize", led_err, err_exp);

    // Timeout: len 2 with only one byte supplied.
    do_reset("reset2");
    abort_cnt = 0;
    pq.delete(); pq.push_back(8'h11);
    send_pkt(3'd0, 5'd2, pq, 1'b0);
    n = 0;
    while (abort_cnt == 0 && n < 300) begin
      step();
      n++;
    end
    err_exp = 1'b1;   // FIFO left empty mid-payload
    check_eq("abort_seen", abort_cnt, 1);
    check_eq("abort_delay", abort_cyc - last_pl_cyc, TIMEOUT_CYC + 1);
    check_eq("err_timeout", led_err, err_exp);
    check_eq("trunc_delivered", exp_pl.size(), 0);
    step();
    check_eq("abort_one_cycle", abort, 0);
    pq.delete(); pq.push_back(8'hC3); pq.push_back(8'h3C);
    send_pkt(3'd5, 5'd2, pq, 1'b1);
    run_drain(200);
    check_eq("abort_total", abort_cnt, 1);

    // Reset one cycle after the first byte of a partial packet.
    do_reset("reset3");
    pq.delete(); pq.push_back(8'hA5);
    send_pkt(3'd2, 5'd4, pq, 1'b0);
    n = 0;
    while (exp_pl.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check_eq("mid_byte1_seen", exp_pl.size(), 0);
    step();
    do_reset("mid_reset");
    pq.delete();
    send_pkt(3'd1, 5'd0, pq, 1'b1);   // byte 0x20 must be taken as a header
    run_drain(200);

    // Random traffic with FIFO gaps and random consumer readiness.
    do_reset("reset4");
    abort_cnt = 0;
    rdy_mode  = 1;
    stall_pct = 25;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(0, 7);
      cmd = 3'($urandom_range(0, 7));
      pq.delete();
      for (int i = 0; i < len; i++) pq.push_back(8'($urandom_range(0, 255)));
      send_pkt(cmd, 5'(len), pq, 1'b1);
    end
    run_drain(8000);
    check_eq("rand_err", led_err, err_exp);
    check_eq("rand_abort", abort_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
